// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: icodes,
// status codes, the null register ID and the controller state enum.
package pipe_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_ADR = 2'd2;
    localparam logic [1:0] ST_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard classification: load/use, return,
// branch mispredict and exception.
module pipe_hazard_detect
    import pipe_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4,
    parameter int STAT_W  = 2
) (
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    output logic               lu,
    output logic               ret,
    output logic               mp,
    output logic               exc
);

    logic e_load;
    logic [ICODE_W-1:0] ic_ret;

    assign ic_ret = ICODE_W'(I_RET);
    assign e_load = (E_icode == ICODE_W'(I_MRMOVQ))
                  | (E_icode == ICODE_W'(I_POPQ));

    // An all-ones destination is the null register and never conflicts
    assign lu = e_load & (E_dstM != '1)
              & ((E_dstM == d_srcA) | (E_dstM == d_srcB));

    assign ret = (D_icode == ic_ret)
               | (E_icode == ic_ret)
               | (M_icode == ic_ret);

    assign mp  = (E_icode == ICODE_W'(I_JXX)) & ~e_cnd;

    assign exc = (m_stat != STAT_W'(ST_AOK))
               | (W_stat != STAT_W'(ST_AOK));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble controller with memory-wait and halt states.
// Optional perf counters enabled by PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 1,
    parameter int STAT_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    output logic               F_stall,
    output logic               D_stall,
    output logic               E_stall,
    output logic               M_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_bubble,
    output logic               set_cc,
    output logic               halted,
    output logic               mem_wait
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt,
    output logic [31:0]        perf_wait_cnt
`endif
);

    localparam int CNT_W = 4;

    state_t     state;
    logic [CNT_W-1:0] cnt;
    logic       wait_done;
    logic       lu, ret, mp, exc;
    logic       w_exc, m_mem;

    pipe_hazard_detect #(
        .ICODE_W (ICODE_W),
        .REG_W   (REG_W),
        .STAT_W  (STAT_W)
    ) u_detect (
        .D_icode (D_icode),
        .E_icode (E_icode),
        .M_icode (M_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_dstM  (E_dstM),
        .e_cnd   (e_cnd),
        .m_stat  (m_stat),
        .W_stat  (W_stat),
        .lu      (lu),
        .ret     (ret),
        .mp      (mp),
        .exc     (exc)
    );

    assign w_exc = (W_stat != STAT_W'(ST_AOK));
    assign m_mem = (M_icode == ICODE_W'(I_RMMOVQ))
                 | (M_icode == ICODE_W'(I_MRMOVQ))
                 | (M_icode == ICODE_W'(I_CALL))
                 | (M_icode == ICODE_W'(I_RET))
                 | (M_icode == ICODE_W'(I_PUSHQ))
                 | (M_icode == ICODE_W'(I_POPQ));

    // wait_done blocks re-entry while the just-served op is still held in M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            wait_done <= 1'b0;
        end else if (w_exc) begin
            state     <= HALT;
            cnt       <= '0;
            wait_done <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    wait_done <= 1'b0;
                    if (MEM_LAT > 1 && m_mem && !exc && !wait_done) begin
                        state <= MWAIT;
                        cnt   <= CNT_W'(MEM_LAT - 1);
                    end
                end
                MWAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        state     <= RUN;
                        cnt       <= '0;
                        wait_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    assign halted   = (state == HALT);
    assign mem_wait = (state == MWAIT);

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        E_stall  = 1'b0;
        M_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        set_cc   = 1'b0;
        unique case (state)
            HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_stall  = 1'b1;
                M_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
            end
            MWAIT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_stall  = 1'b1;
                M_stall  = 1'b1;
                W_bubble = 1'b1;
            end
            default: begin
                F_stall  = lu | ret;
                D_stall  = lu;
                D_bubble = mp | (ret & ~lu);
                E_bubble = mp | lu;
                M_bubble = exc;
                W_stall  = w_exc;
                set_cc   = (E_icode == ICODE_W'(I_OPQ)) & ~exc;
            end
        endcase
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
            perf_wait_cnt   <= '0;
        end else begin
            if (F_stall && state == RUN && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((D_bubble || E_bubble) && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (state == MWAIT && perf_wait_cnt != '1)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus
// multi-cycle wait/halt/reset sequences, scoreboard-compared.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    typedef logic [11:0] ovec_t;

    localparam ovec_t O_F  = 12'h800;
    localparam ovec_t O_D  = 12'h400;
    localparam ovec_t O_E  = 12'h200;
    localparam ovec_t O_M  = 12'h100;
    localparam ovec_t O_W  = 12'h080;
    localparam ovec_t O_DB = 12'h040;
    localparam ovec_t O_EB = 12'h020;
    localparam ovec_t O_MB = 12'h010;
    localparam ovec_t O_WB = 12'h008;
    localparam ovec_t O_CC = 12'h004;
    localparam ovec_t O_HL = 12'h002;
    localparam ovec_t O_MW = 12'h001;
    localparam ovec_t O_WAIT = O_F | O_D | O_E | O_M | O_WB | O_MW;
    localparam ovec_t O_HALT = O_F | O_D | O_E | O_M | O_W | O_MB | O_HL;

    typedef struct {
        logic [3:0] di, ei, mi, sa, sb, dm;
        logic       cnd;
        logic [1:0] ms, ws;
        ovec_t      exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] D_icode, E_icode, M_icode;
    logic [3:0] d_srcA, d_srcB, E_dstM;
    logic       e_cnd;
    logic [1:0] m_stat, W_stat;

    logic a_fs, a_ds, a_es, a_ms, a_ws, a_db, a_eb, a_mb, a_wb;
    logic a_cc, a_hl, a_mw;
    logic b_fs, b_ds, b_es, b_ms, b_ws, b_db, b_eb, b_mb, b_wb;
    logic b_cc, b_hl, b_mw;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] a_ps, a_pb, a_pw, b_ps, b_pb, b_pw;
`endif

    ovec_t a_out;
    assign a_out = {a_fs, a_ds, a_es, a_ms, a_ws, a_db,
                    a_eb, a_mb, a_wb, a_cc, a_hl, a_mw};

    pipe_hazard_ctrl #(.MEM_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
        .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(a_fs), .D_stall(a_ds), .E_stall(a_es),
        .M_stall(a_ms), .W_stall(a_ws),
        .D_bubble(a_db), .E_bubble(a_eb), .M_bubble(a_mb),
        .W_bubble(a_wb), .set_cc(a_cc), .halted(a_hl),
        .mem_wait(a_mw)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cnt(a_ps), .perf_bubble_cnt(a_pb),
        .perf_wait_cnt(a_pw)
`endif
    );

    pipe_hazard_ctrl #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
        .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(b_fs), .D_stall(b_ds), .E_stall(b_es),
        .M_stall(b_ms), .W_stall(b_ws),
        .D_bubble(b_db), .E_bubble(b_eb), .M_bubble(b_mb),
        .W_bubble(b_wb), .set_cc(b_cc), .halted(b_hl),
        .mem_wait(b_mw)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cnt(b_ps), .perf_bubble_cnt(b_pb),
        .perf_wait_cnt(b_pw)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    ovec_t sbq[$];
    vec_t  vt[10];

    task automatic set_nop();
        D_icode = I_NOP;
        E_icode = I_NOP;
        M_icode = I_NOP;
        d_srcA  = REG_NONE;
        d_srcB  = REG_NONE;
        E_dstM  = REG_NONE;
        e_cnd   = 1'b0;
        m_stat  = ST_AOK;
        W_stat  = ST_AOK;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // push expectation for the stimulus just driven, compare at negedge
    task automatic go(input string nm, input ovec_t exp);
        ovec_t e;
        sbq.push_back(exp);
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", nm, a_out);
        end else begin
            e = sbq.pop_front();
            if (a_out !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, a_out, e);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        logic b_exp_mw[10];
        logic [3:0] mseq[10];

        vt[0] = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 12'h000};
        vt[1] = '{4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b0, 2'd0, 2'd0, O_F | O_D | O_EB};
        vt[2] = '{4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 12'h000};
        vt[3] = '{4'h1, 4'hB, 4'h1, 4'h1, 4'h4, 4'h4, 1'b0, 2'd0, 2'd0, O_F | O_D | O_EB};
        vt[4] = '{4'h1, 4'h6, 4'h1, 4'h1, 4'h2, 4'hF, 1'b0, 2'd0, 2'd0, O_CC};
        vt[5] = '{4'h1, 4'h6, 4'h1, 4'h1, 4'h2, 4'hF, 1'b0, 2'd2, 2'd0, O_MB};
        vt[6] = '{4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, O_DB | O_EB};
        vt[7] = '{4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 12'h000};
        vt[8] = '{4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, O_F | O_DB};
        vt[9] = '{4'h9, 4'h5, 4'h1, 4'h2, 4'hF, 4'h2, 1'b0, 2'd0, 2'd0, O_F | O_D | O_EB};

        rst_n = 1'b0;
        set_nop();
        go("reset_outputs", 12'h000);
        chk("reset_b_mem_wait", 32'(b_mw), 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("reset_perf_wait", a_pw, 32'd0);
`endif
        adv();
        rst_n = 1'b1;
        go("run_idle", 12'h000);

        for (int i = 0; i < 10; i++) begin
            adv();
            D_icode = vt[i].di;
            E_icode = vt[i].ei;
            M_icode = vt[i].mi;
            d_srcA  = vt[i].sa;
            d_srcB  = vt[i].sb;
            E_dstM  = vt[i].dm;
            e_cnd   = vt[i].cnd;
            m_stat  = vt[i].ms;
            W_stat  = vt[i].ws;
            go($sformatf("vec%0d", i), vt[i].exp);
        end

        // return moving through D, E, then M (M also starts a wait)
        for (int i = 0; i < 3; i++) begin
            adv();
            set_nop();
            D_icode = I_RET;
            go($sformatf("ret_d%0d", i), O_F | O_DB);
        end
        adv();
        set_nop();
        E_icode = I_RET;
        go("ret_e", O_F | O_DB);
        adv();
        set_nop();
        M_icode = I_RET;
        go("ret_m", O_F | O_DB);
        for (int i = 0; i < 3; i++) begin
            adv();
            go($sformatf("ret_wait%0d", i), O_WAIT);
        end
        adv();
        go("ret_after_wait", O_F | O_DB);
        adv();
        set_nop();
        go("ret_clear", 12'h000);

        // clean restart so both instances start aligned
        adv();
        rst_n = 1'b0;
        go("rst_a", 12'h000);
        adv();
        rst_n = 1'b1;
        go("rst_a_rel", 12'h000);

        // MEM_LAT=4 store: entry cycle, three wait cycles, back to run
        adv();
        M_icode = I_RMMOVQ;
        go("mw_entry", 12'h000);
        for (int i = 0; i < 3; i++) begin
            adv();
            go($sformatf("mw_wait%0d", i), O_WAIT);
        end
        adv();
        go("mw_done", 12'h000);
        adv();
        set_nop();
        go("mw_idle", 12'h000);

        // exception in W while running, then sticky halt
        adv();
        W_stat = ST_HLT;
        go("w_exc_run", O_W | O_MB);
        adv();
        W_stat = ST_AOK;
        go("halt_a", O_HALT);
        adv();
        go("halt_a_hold", O_HALT);
        adv();
        rst_n = 1'b0;
        go("halt_a_rst", 12'h000);
        adv();
        rst_n = 1'b1;
        go("halt_a_rel", 12'h000);

        // W exception during a memory wait
        adv();
        M_icode = I_MRMOVQ;
        go("hw_entry", 12'h000);
        adv();
        W_stat = ST_ADR;
        go("hw_wait", O_WAIT);
        adv();
        W_stat = ST_AOK;
        M_icode = I_NOP;
        go("hw_halt", O_HALT);
        for (int i = 0; i < 3; i++) begin
            adv();
            go($sformatf("hw_sticky%0d", i), O_HALT);
        end
        adv();
        rst_n = 1'b0;
        go("hw_rst", 12'h000);
        adv();
        rst_n = 1'b1;
        go("hw_rel", 12'h000);

        // reset in the middle of a wait leaves no residual wait
        adv();
        M_icode = I_PUSHQ;
        go("rw_entry", 12'h000);
        adv();
        go("rw_wait", O_WAIT);
        adv();
        rst_n = 1'b0;
        M_icode = I_NOP;
        go("rw_rst", 12'h000);
        adv();
        rst_n = 1'b1;
        go("rw_rel", 12'h000);
        adv();
        go("rw_run", 12'h000);

        // MEM_LAT=3 instance: two memory ops, two wait cycles each
        mseq = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h1,
                 4'h5, 4'h5, 4'h5, 4'h5, 4'h1};
        b_exp_mw = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            adv();
            M_icode = mseq[i];
            @(negedge clk);
            chk($sformatf("lat3_mw%0d", i), 32'(b_mw), 32'(b_exp_mw[i]));
        end
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_wait", b_pw, 32'd4);
        chk("perf_stall", b_ps, 32'd0);
        chk("perf_bubble", b_pb, 32'd0);
`endif

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter ICODE_W, default 4, instruction-code width.
REQ-002 SHALL have parameter REG_W, default 4, register-ID width; ID 4'hF (all ones) means "no register".
REQ-003 SHALL have parameter MEM_LAT, default 1, data-memory latency in cycles; legal 1..8.
REQ-004 SHALL have parameter STAT_W, default 2, status width.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- D_icode, E_icode, M_icode  in  ICODE_W  stage instruction codes.
- d_srcA, d_srcB  in  REG_W  decode source registers.
- E_dstM  in  REG_W  execute-stage load destination.
- e_cnd  in  1  execute branch condition.
- m_stat, W_stat  in  STAT_W  memory/writeback status.
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1  hold stage register.
- D_bubble, E_bubble, M_bubble, W_bubble  out  1  insert nop into stage register.
- set_cc  out  1  condition-code write enable.
- halted  out  1  sticky halt indication.
- mem_wait  out  1  controller is in a memory wait.

Function
REQ-010 SHALL declare a load/use hazard (LU) when E_icode is MRMOVQ (5) or POPQ (11), E_dstM != 4'hF, and E_dstM equals d_srcA or d_srcB.
REQ-011 SHALL declare a return hazard (RET) when any of D_icode, E_icode, M_icode is RET (9).
REQ-012 SHALL declare a mispredict (MP) when E_icode is JXX (7) and e_cnd=0.
REQ-013 SHALL declare an exception (EXC) when m_stat != AOK or W_stat != AOK.
REQ-014 In state RUN, the outputs SHALL be:
- F_stall = LU | RET
- D_stall = LU
- D_bubble = MP | (RET & ~LU)
- E_bubble = MP | LU
- M_bubble = EXC
- W_stall = (W_stat != AOK)
- set_cc = (E_icode == OPQ (6)) & ~EXC
- all other stall and bubble outputs = 0
REQ-015 SHALL implement the FSM states RUN, MWAIT and HALT.
REQ-016 RUN SHALL go to MWAIT when MEM_LAT>1, M_icode is a memory op (4, 5, 8, 9, 10, 11) and EXC=0.
REQ-017 MWAIT SHALL load a down-counter with MEM_LAT-1 on entry, decrement it each cycle, and return to RUN when it reaches 0.
REQ-018 While in MWAIT, the outputs SHALL be:
- F_stall = D_stall = E_stall = M_stall = 1
- W_bubble = 1
- set_cc = 0
- mem_wait = 1
- all other outputs = 0
REQ-019 Any state SHALL go to HALT when W_stat != AOK; HALT takes priority over MWAIT entry and continuation.
REQ-020 HALT SHALL be sticky until reset, with the outputs:
- all stall outputs = 1
- M_bubble = 1
- set_cc = 0
- halted = 1
REQ-021 On the cycle an instruction enters MWAIT, the RUN-state outputs SHALL still apply; the wait begins on the following cycle.
REQ-022 With MEM_LAT=1, MWAIT SHALL never be entered and behaviour SHALL be purely combinational from the inputs.
REQ-023 Priority SHALL be HALT > MWAIT > RUN rules; within RUN, LU+RET simultaneous gives stall, not bubble, at D.

Reset
REQ-030 While rst_n=0:
- the state SHALL be RUN
- the counter SHALL be 0
- halted and mem_wait SHALL be 0
- performance counters SHALL be 0
REQ-031 Deassertion of rst_n mid-MWAIT or in HALT SHALL restart in RUN with no residual wait cycles.

Configuration
REQ-040 With PIPE_HAZARD_PERF_EN defined, the block SHALL add the outputs perf_stall_cnt, perf_bubble_cnt and perf_wait_cnt, each 32 bits, counting:
- cycles with F_stall=1 and state RUN
- cycles with D_bubble or E_bubble = 1
- cycles in MWAIT
REQ-041 Each performance counter SHALL saturate at 32'hFFFF_FFFF.
REQ-042 Without PIPE_HAZARD_PERF_EN, the performance ports and logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-050 A shared package pipe_pkg SHALL hold:
- the icode constants (HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=10, POPQ=11)
- the status constants (AOK=0, HLT=1, ADR=2, INS=3)
- the REG_NONE constant
- the FSM state enum
REQ-051 Hazard detection SHALL be a combinational sub-module pipe_hazard_detect producing LU, RET, MP and EXC; the FSM and counters SHALL stay in the top module.

Verification
REQ-060 The bench SHALL apply E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-061 The bench SHALL apply E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0.
REQ-062 The bench SHALL apply D_icode=9 for 3 cycles, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 each cycle.
REQ-063 With MEM_LAT=4, the bench SHALL apply M_icode=4 -> mem_wait=1 and M_stall=1 for exactly 3 cycles after the entry cycle, then return to RUN.
REQ-064 The bench SHALL apply W_stat=ADR during MWAIT -> HALT on the next cycle with halted=1, and SHALL hold there until rst_n=0.
REQ-065 With PIPE_HAZARD_PERF_EN and MEM_LAT=3, the bench SHALL issue two memory ops -> perf_wait_cnt=4.
